// File: rtl/mx_apb_master.sv
// mx_apb_master: APB3 initiator bridging a single-outstanding valid/ready
// register-access request onto SETUP/ACCESS phases, with an optional
// ACCESS-phase timeout and a held valid/ready response.
module mx_apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        PClkxCI,
    input  logic        PResetxARBI,
    input  logic        ReqValidxSI,
    output logic        ReqReadyxSO,
    input  logic        ReqWritexSI,
    input  logic [29:0] ReqAddrxDI,
    input  logic [31:0] ReqWDataxDI,
    output logic        RspValidxSO,
    input  logic        RspReadyxSI,
    output logic [31:0] RspRDataxDO,
    output logic        RspErrxSO,
    output logic        RspTimeoutxSO,
    output logic        PEnClkxSO,
    output logic        PSelxSO,
    output logic        PEnablexSO,
    output logic        PWritexSO,
    output logic [29:0] PAddrxDO,
    output logic [31:0] PWDataxDO,
    input  logic        PReadyxSI,
    input  logic [31:0] PRDataxDI,
    input  logic        PSlverrxSI
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Counter holds the number of ACCESS cycles already completed; the
    // timeout fires on the ACCESS cycle whose count equals TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic            TO_EN   = (TIMEOUT_CYCLES != 32'd0);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [29:0]     paddr_q, paddr_d;
    logic [31:0]     pwdata_q, pwdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_to_q, rsp_to_d;
    logic            timeout_hit_s;

    assign timeout_hit_s = TO_EN && (cnt_q == TO_LAST);

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        case (state_q)
            ST_IDLE: begin
                if (ReqValidxSI && req_ready_q) begin
                    state_d     = ST_SETUP;
                    req_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = ReqWritexSI;
                    paddr_d     = ReqAddrxDI;
                    pwdata_d    = ReqWDataxDI;
                    cnt_d       = '0;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (PReadyxSI) begin
                    // PReady wins over a coincident timeout.
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (pwrite_q || PSlverrxSI) ? 32'h0000_0000 : PRDataxDI;
                    rsp_err_d   = PSlverrxSI;
                    rsp_to_d    = 1'b0;
                end else if (timeout_hit_s) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else begin
                    cnt_d = (cnt_q == TO_SAT) ? cnt_q : cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                if (RspReadyxSI) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b0;
            end
        endcase
    end

    // State and registered-output update; async reset idles the bus at once.
    always_ff @(posedge PClkxCI or negedge PResetxARBI) begin
        if (!PResetxARBI) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 30'd0;
            pwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    // The clock-enable request follows PSel: high exactly in SETUP and ACCESS.
    assign ReqReadyxSO   = req_ready_q;
    assign PEnClkxSO     = psel_q;
    assign PSelxSO       = psel_q;
    assign PEnablexSO    = penable_q;
    assign PWritexSO     = pwrite_q;
    assign PAddrxDO      = paddr_q;
    assign PWDataxDO     = pwdata_q;
    assign RspValidxSO   = rsp_valid_q;
    assign RspRDataxDO   = rsp_rdata_q;
    assign RspErrxSO     = rsp_err_q;
    assign RspTimeoutxSO = rsp_to_q;

endmodule

// File: tb/tb_mx_apb_master.sv
// Self-checking bench for mx_apb_master (TIMEOUT_CYCLES=8): table of
// transactions with a response scoreboard, plus a mid-transfer reset sequence.
module tb_mx_apb_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_to;
    logic        penclk, psel, penable, pwrite;
    logic [29:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          waitc;
        logic        slverr;
        logic [31:0] prdata;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_pen;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t sb_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    mx_apb_master #(.TIMEOUT_CYCLES(8), .TO_W(8)) dut (
        .PClkxCI(clk), .PResetxARBI(rst_n),
        .ReqValidxSI(req_valid), .ReqReadyxSO(req_ready), .ReqWritexSI(req_write),
        .ReqAddrxDI(req_addr), .ReqWDataxDI(req_wdata),
        .RspValidxSO(rsp_valid), .RspReadyxSI(rsp_ready), .RspRDataxDO(rsp_rdata),
        .RspErrxSO(rsp_err), .RspTimeoutxSO(rsp_to),
        .PEnClkxSO(penclk), .PSelxSO(psel), .PEnablexSO(penable), .PWritexSO(pwrite),
        .PAddrxDO(paddr), .PWDataxDO(pwdata),
        .PReadyxSI(pready), .PRDataxDI(prdata), .PSlverrxSI(pslverr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_txn(input vec_t v);
        int   w;
        int   pen;
        bit   done;
        rsp_t r;
        rsp_t e;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.to    = v.exp_to;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        req_addr  = 30'h3FFF_FFFF;
        // SETUP phase
        chk("setup_psel", {31'd0, psel}, 32'd1);
        chk("setup_penable", {31'd0, penable}, 32'd0);
        chk("setup_penclk", {31'd0, penclk}, 32'd1);
        chk("setup_paddr", {2'b00, paddr}, {2'b00, v.addr});
        chk("setup_pwdata", pwdata, v.wdata);
        chk("setup_pwrite", {31'd0, pwrite}, {31'd0, v.wr});
        chk("setup_reqready", {31'd0, req_ready}, 32'd0);
        pen  = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (penable) begin
                pen++;
                chk("access_psel", {31'd0, psel}, 32'd1);
                chk("access_paddr", {2'b00, paddr}, {2'b00, v.addr});
                chk("access_pwdata", pwdata, v.wdata);
                pready  = (pen == v.waitc + 1);
                pslverr = pready ? v.slverr : 1'b1;
                prdata  = pready ? v.prdata : 32'hBAD0_BAD0;
            end else begin
                done = 1'b1;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        chk("access_bound", {31'd0, done}, 32'd1);
        chk("penable_cycles", pen, v.exp_pen);
        chk("resp_psel", {31'd0, psel}, 32'd0);
        chk("resp_penclk", {31'd0, penclk}, 32'd0);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
            chk("rsp_timeout", {31'd0, rsp_to}, {31'd0, r.to});
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk);
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_rdata", rsp_rdata, r.rdata);
                chk("stall_err", {31'd0, rsp_err}, {31'd0, r.err});
                chk("stall_timeout", {31'd0, rsp_to}, {31'd0, r.to});
                chk("stall_reqready", {31'd0, req_ready}, 32'd0);
            end
        end else begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rsp_reqready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int stray;
        //         wr    addr        wdata         wait slv prdata        stall exp_rdata     err   to    pen
        vecs[0] = '{1'b1, 30'h0000_4010, 32'hDEAD_BEEF, 0,  1'b0, 32'h1111_1111, 0,  32'h0,         1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 30'h0000_0123, 32'h0,         4,  1'b0, 32'h1234_5678, 10, 32'h1234_5678, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b0, 30'h0ABC_0001, 32'h0,         2,  1'b1, 32'h5555_AAAA, 0,  32'h0,         1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 30'h0000_0777, 32'h0,         99, 1'b0, 32'h0,         2,  32'h0,         1'b1, 1'b1, 8};
        vecs[4] = '{1'b0, 30'h1000_0002, 32'h0,         7,  1'b0, 32'hAAAA_5555, 0,  32'hAAAA_5555, 1'b0, 1'b0, 8};
        vecs[5] = '{1'b1, 30'h2222_2222, 32'h0BAD_F00D, 3,  1'b0, 32'hCAFE_CAFE, 0,  32'h0,         1'b0, 1'b0, 4};
        vecs[6] = '{1'b1, 30'h3FFF_FFFF, 32'hFFFF_0000, 99, 1'b0, 32'h0,         0,  32'h0,         1'b1, 1'b1, 8};
        vecs[7] = '{1'b0, 30'h0000_0000, 32'h0,         6,  1'b0, 32'h0F0F_0F0F, 1,  32'h0F0F_0F0F, 1'b0, 1'b0, 7};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 30'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = 32'h0;
        pslverr   = 1'b0;
        #1;
        chk("reset_reqready", {31'd0, req_ready}, 32'd0);
        chk("reset_psel", {31'd0, psel}, 32'd0);
        chk("reset_rspvalid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_paddr", {2'b00, paddr}, 32'd0);
        chk("reset_pwdata", pwdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_reqready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reset pulled in the middle of ACCESS
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 30'h0000_0055;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_penable_before", {31'd0, penable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", {31'd0, psel}, 32'd0);
        chk("rst_mid_penable", {31'd0, penable}, 32'd0);
        chk("rst_mid_penclk", {31'd0, penclk}, 32'd0);
        chk("rst_mid_rspvalid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        chk("rst_no_stray_rsp", stray, 32'd0);
        chk("rst_after_reqready", {31'd0, req_ready}, 32'd1);
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
